// File: rtl/adc_axis_packer_pkg.sv
// Shared types and helpers for the ADC-to-AXI-Stream packer.
// Imported by the packer top level and its testbench.
package adc_axis_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} packer_state_t;

  localparam logic [31:0] FILL_WORD = 32'hFFFF_FFFF;

  // Lanes whose strobe bit is low are forced to zero in the packed word.
  function automatic logic [31:0] pack_word(input logic [31:0] data, input logic [1:0] valid);
    pack_word = {valid[1] ? data[31:16] : 16'h0000,
                 valid[0] ? data[15:0]  : 16'h0000};
  endfunction

endpackage

// File: rtl/adc_axis_packer_if.sv
// AXI4-Stream bundle between the packer and the downstream interconnect.
interface adc_axis_packer_if;

  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/adc_axis_packer_fifo.sv
// Synchronous FIFO with extra-bit pointers; a push while full is taken
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       pushData_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       popData_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             doPush;
  logic             doPop;

  assign level_o   = wrPtr_q - rdPtr_q;
  assign full_o    = (level_o == (AW+1)'(DEPTH));
  assign empty_o   = (level_o == '0);
  assign popData_o = mem_q[rdPtr_q[AW-1:0]];

  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + (AW+1)'(1);
    if (doPop)  rdPtr_d = rdPtr_q + (AW+1)'(1);
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge i_clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

endmodule

// File: rtl/adc_axis_packer.sv
// Packs dual-channel ADC samples into 32-bit AXI-Stream words with framed
// tlast, FIFO buffering, drain terminator and overflow accounting.
module adc_axis_packer
  import adc_axis_pkg::*;
#(
  parameter int ADC_LENGTH = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 256
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [2*ADC_LENGTH-1:0]     i_data,
  input  logic [1:0]                  i_tValid,
  input  logic                        i_enable,
  adc_axis_packer_if.master           m_axis,
  output logic                        o_overflow,
  output logic [15:0]                 o_dropCount,
  output logic [$clog2(FIFO_DEPTH):0] o_level
);

  localparam int FCW = $clog2(FRAME_LEN);
  localparam logic [FCW-1:0] LAST_CNT = FCW'(FRAME_LEN - 1);

  packer_state_t  state_q, state_d;
  logic [FCW-1:0] frameCnt_q, frameCnt_d;
  logic           capValid_q, capValid_d;
  logic [31:0]    capWord_q, capWord_d;
  logic           overflow_q, overflow_d;
  logic [15:0]    dropCnt_q, dropCnt_d;
  logic           outValid_q, outValid_d;
  logic [32:0]    outData_q, outData_d;

  logic        capture;
  logic [31:0] laneData;
  logic        fillReq;
  logic        pushReq;
  logic        pushAccept;
  logic        canPush;
  logic        isLast;
  logic [32:0] pushEntry;
  logic        outLoad;
  logic        fifoPop;
  logic        fifoFull;
  logic        fifoEmpty;
  logic [32:0] fifoData;

  // Samples land in a capture register first; the push and the full/drop
  // decision happen one cycle later against the FIFO's registered state.
  assign capture  = (state_q == RUN) && i_enable && (i_tValid != 2'b00);
  assign laneData = {16'(i_data[2*ADC_LENGTH-1:ADC_LENGTH]), 16'(i_data[ADC_LENGTH-1:0])};

  assign fillReq    = (state_q == DRAIN) && !capValid_q;
  assign pushReq    = capValid_q || fillReq;
  assign outLoad    = !outValid_q || m_axis.tready;
  assign fifoPop    = outLoad && !fifoEmpty;
  assign canPush    = !fifoFull || fifoPop;
  assign pushAccept = pushReq && canPush;
  assign isLast     = (frameCnt_q == LAST_CNT);
  assign pushEntry  = capValid_q ? {isLast, capWord_q} : {1'b1, FILL_WORD};

  sync_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .push_i     (pushAccept),
    .pushData_i (pushEntry),
    .pop_i      (fifoPop),
    .popData_o  (fifoData),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .level_o    (o_level)
  );

  always_comb begin
    capValid_d = capture;
    capWord_d  = capture ? pack_word(laneData, i_tValid) : capWord_q;

    frameCnt_d = frameCnt_q;
    if (pushAccept) begin
      if (capValid_q) frameCnt_d = isLast ? '0 : frameCnt_q + FCW'(1);
      else            frameCnt_d = '0;
    end

    overflow_d = overflow_q;
    dropCnt_d  = dropCnt_q;
    if (capValid_q && !canPush) begin
      overflow_d = 1'b1;
      if (dropCnt_q != 16'hFFFF) dropCnt_d = dropCnt_q + 16'd1;
    end

    outValid_d = outValid_q;
    outData_d  = outData_q;
    if (outLoad) begin
      outValid_d = !fifoEmpty;
      if (!fifoEmpty) outData_d = fifoData;
    end
  end

  // The stop decision looks at the frame count after any pending push, so a
  // frame completed by the final sample does not get a spurious terminator.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_enable) state_d = RUN;
      RUN:     if (!i_enable) state_d = (frameCnt_d == '0) ? IDLE : DRAIN;
      DRAIN:   if (pushAccept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      frameCnt_q <= '0;
      capValid_q <= 1'b0;
      capWord_q  <= '0;
      overflow_q <= 1'b0;
      dropCnt_q  <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else begin
      state_q    <= state_d;
      frameCnt_q <= frameCnt_d;
      capValid_q <= capValid_d;
      capWord_q  <= capWord_d;
      overflow_q <= overflow_d;
      dropCnt_q  <= dropCnt_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
    end
  end

  assign m_axis.tvalid = outValid_q;
  assign m_axis.tdata  = outData_q[31:0];
  assign m_axis.tlast  = outData_q[32];
  assign o_overflow    = overflow_q;
  assign o_dropCount   = dropCnt_q;

endmodule

// File: tb/tb_adc_axis_packer.sv
// Self-checking bench for adc_axis_packer: a queue model of the stream
// plus literal expectations for latency, packing, drain, overflow and reset.
module tb_adc_axis_packer;
  import adc_axis_pkg::*;

  localparam int AL    = 12;
  localparam int DEPTH = 16;
  localparam int FLEN  = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [2*AL-1:0] i_data;
  logic [1:0]    i_tValid;
  logic          i_enable;
  logic          readyReg;
  logic          o_overflow;
  logic [15:0]   o_dropCount;
  logic [4:0]    o_level;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] expQ[$];
  int          modelFcnt = 0;
  bit          modelRun = 0;
  bit          skipCompare = 1;
  int          readyMode = 1;

  always #5 i_clk = ~i_clk;

  adc_axis_packer_if axis();
  assign axis.tready = readyReg;

  adc_axis_packer #(
    .ADC_LENGTH (AL),
    .FIFO_DEPTH (DEPTH),
    .FRAME_LEN  (FLEN)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_tValid    (i_tValid),
    .i_enable    (i_enable),
    .m_axis      (axis),
    .o_overflow  (o_overflow),
    .o_dropCount (o_dropCount),
    .o_level     (o_level)
  );

  task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // One-cycle strobe; the model decides acceptance from outstanding words.
  task automatic applyStimulus(input logic [AL-1:0] ch0, input logic [AL-1:0] ch1, input logic [1:0] v);
    logic [31:0] w;
    i_data   = {ch1, ch0};
    i_tValid = v;
    w = {v[1] ? {4'h0, ch1} : 16'h0000, v[0] ? {4'h0, ch0} : 16'h0000};
    if (modelRun) begin
      if (expQ.size() < DEPTH + 1) begin
        expQ.push_back({(modelFcnt == FLEN - 1), w});
        modelFcnt = (modelFcnt + 1) % FLEN;
      end
    end
    @(posedge i_clk);
    #1;
    i_tValid = 2'b00;
  endtask

  task automatic setEnable(input bit en);
    i_enable = en;
    if (!en && modelRun && modelFcnt != 0) begin
      expQ.push_back({1'b1, FILL_WORD});
      modelFcnt = 0;
    end
    modelRun = en;
    idle(1);
  endtask

  task automatic expectWord(input logic [31:0] d, input bit l, input int limit);
    int k = 0;
    bit seen = 0;
    while (!seen && k < limit) begin
      @(negedge i_clk);
      if (axis.tvalid && axis.tdata == d) seen = 1;
      else k++;
    end
    checkOutput($sformatf("word %h seen", d), 33'(seen), 33'd1);
    if (seen) checkOutput($sformatf("word %h tlast", d), 33'(axis.tlast), 33'(l));
  endtask

  task automatic waitEmpty(input int limit);
    int k = 0;
    while ((expQ.size() != 0 || axis.tvalid) && k < limit) begin
      idle(1);
      k++;
    end
    checkOutput("stream drained", 33'(expQ.size()), 33'd0);
  endtask

  task automatic readyLoop();
    forever begin
      @(posedge i_clk);
      #1;
      if (readyMode == 2) readyReg = 1'($urandom_range(0, 1));
      else                readyReg = (readyMode == 1);
    end
  endtask

  // Every cycle with tvalid high is checked against the model head; a
  // stalled word must reappear unchanged on the next cycle.
  task automatic compareLoop();
    logic [32:0] held = '0;
    bit stalled = 0;
    forever begin
      @(negedge i_clk);
      if (skipCompare) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          checkOutput("stall tvalid", 33'(axis.tvalid), 33'd1);
          checkOutput("stall hold", {axis.tlast, axis.tdata}, held);
        end
        stalled = 0;
        if (axis.tvalid) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected word tvalid", 33'(axis.tvalid), 33'd0);
          end else begin
            checkOutput("stream word", {axis.tlast, axis.tdata}, expQ[0]);
            if (axis.tready) begin
              void'(expQ.pop_front());
            end else begin
              stalled = 1;
              held = {axis.tlast, axis.tdata};
            end
          end
        end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    i_rst = 1'b0;
    i_data = '0;
    i_tValid = 2'b00;
    i_enable = 1'b0;
    readyReg = 1'b1;
    fork
      compareLoop();
      readyLoop();
    join_none

    // Reset values
    idle(3);
    checkOutput("reset tvalid", 33'(axis.tvalid), 33'd0);
    checkOutput("reset tdata", 33'(axis.tdata), 33'd0);
    checkOutput("reset tlast", 33'(axis.tlast), 33'd0);
    checkOutput("reset level", 33'(o_level), 33'd0);
    checkOutput("reset overflow", 33'(o_overflow), 33'd0);
    checkOutput("reset dropCount", 33'(o_dropCount), 33'd0);
    i_rst = 1'b1;
    skipCompare = 0;
    idle(1);

    // One frame pair with latency pinned on the first word
    setEnable(1);
    applyStimulus(12'h001, 12'h101, 2'b11);
    @(negedge i_clk);
    checkOutput("latency edge N tvalid", 33'(axis.tvalid), 33'd0);
    checkOutput("latency edge N level", 33'(o_level), 33'd0);
    @(negedge i_clk);
    checkOutput("latency edge N+1 tvalid", 33'(axis.tvalid), 33'd0);
    checkOutput("latency edge N+1 level", 33'(o_level), 33'd1);
    @(negedge i_clk);
    checkOutput("latency edge N+2 tvalid", 33'(axis.tvalid), 33'd1);
    checkOutput("first word", {axis.tlast, axis.tdata}, {1'b0, 32'h0101_0001});
    idle(1);
    fork
      begin
        for (int i = 2; i <= 8; i++) begin
          applyStimulus(12'(i), 12'(12'h100 + i), 2'b11);
          idle(1);
        end
      end
      begin
        expectWord(32'h0103_0003, 1'b0, 40);
        expectWord(32'h0104_0004, 1'b1, 10);
        expectWord(32'h0108_0008, 1'b1, 40);
      end
    join
    waitEmpty(50);

    // Single-lane packing
    fork
      applyStimulus(12'h123, 12'hABC, 2'b01);
      expectWord(32'h0000_0123, 1'b0, 10);
    join
    idle(2);
    fork
      applyStimulus(12'h123, 12'hABC, 2'b10);
      expectWord(32'h0ABC_0000, 1'b0, 10);
    join
    idle(4);

    // Mid-frame disable produces a terminator, then strobes are ignored
    fork
      setEnable(0);
      expectWord(32'hFFFF_FFFF, 1'b1, 20);
    join
    waitEmpty(20);
    applyStimulus(12'h555, 12'h555, 2'b11);
    idle(5);
    checkOutput("ignored strobe level", 33'(o_level), 33'd0);
    checkOutput("ignored strobe tvalid", 33'(axis.tvalid), 33'd0);
    checkOutput("ignored strobe dropCount", 33'(o_dropCount), 33'd0);
    setEnable(1);

    // Random backpressure
    readyMode = 2;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(12'($urandom), 12'($urandom), 2'($urandom_range(1, 3)));
      idle(2);
    end
    readyMode = 1;
    waitEmpty(100);
    checkOutput("random dropCount", 33'(o_dropCount), 33'd0);
    checkOutput("random overflow", 33'(o_overflow), 33'd0);

    // Overflow with tready held low
    readyMode = 0;
    idle(2);
    for (int i = 0; i < DEPTH + 4; i++) begin
      applyStimulus(12'(i), 12'(12'h200 + i), 2'b11);
    end
    idle(4);
    checkOutput("overflow level", 33'(o_level), 33'd16);
    checkOutput("overflow dropCount", 33'(o_dropCount), 33'd3);
    checkOutput("overflow flag", 33'(o_overflow), 33'd1);
    readyMode = 1;
    waitEmpty(100);
    checkOutput("overflow sticky", 33'(o_overflow), 33'd1);
    checkOutput("dropCount held", 33'(o_dropCount), 33'd3);
    checkOutput("overflow drained level", 33'(o_level), 33'd0);

    // Reset with buffered data
    readyMode = 0;
    idle(2);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(12'(12'h300 + i), 12'(12'h400 + i), 2'b11);
    end
    idle(4);
    checkOutput("pre-reset level", 33'(o_level), 33'd5);
    skipCompare = 1;
    i_rst = 1'b0;
    expQ.delete();
    modelFcnt = 0;
    idle(1);
    i_rst = 1'b1;
    checkOutput("post-reset tvalid", 33'(axis.tvalid), 33'd0);
    checkOutput("post-reset tdata", 33'(axis.tdata), 33'd0);
    checkOutput("post-reset tlast", 33'(axis.tlast), 33'd0);
    checkOutput("post-reset level", 33'(o_level), 33'd0);
    checkOutput("post-reset overflow", 33'(o_overflow), 33'd0);
    checkOutput("post-reset dropCount", 33'(o_dropCount), 33'd0);
    skipCompare = 0;
    readyMode = 1;
    idle(10);
    fork
      applyStimulus(12'h7AA, 12'h0BB, 2'b11);
      expectWord(32'h00BB_07AA, 1'b0, 10);
    join
    waitEmpty(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_axis_packer.md
# adc_axis_packer

Downstream stage of the dual-channel AD7276 SPI receiver. Captures each 2×12-bit conversion result, packs it into one 32-bit AXI4-Stream word and buffers it in a synchronous FIFO. Drives a backpressured master stream toward the DMA with frame-based `tlast`, and reports drops caused by overflow. Sits between the SPI receiver and the AXI-Stream interconnect inside the axis_ad7276 IP.

## Interface
Parameters:
- `ADC_LENGTH`, 12: bits per channel sample; must be ≤ 16.
- `FIFO_DEPTH`, 16: storage entries; power of two, ≥ 4.
- `FRAME_LEN`, 256: words per frame; ≥ 2.

Ports:
- `i_clk` in 1: clock, shared with the SPI receiver.
- `i_rst` in 1: reset, synchronous, active-low; clock `i_clk`.
- `i_data` in 2*ADC_LENGTH: `[ADC_LENGTH-1:0]` is ch0 and the upper half is ch1. Valid only in a cycle where `i_tValid` is nonzero.
- `i_tValid` in 2: per-channel 1-cycle strobe.
- `i_enable` in 1: capture enable; level-sensitive.
- `m_axis_tdata` out 32: `{ch1 zero-extended to 16, ch0 zero-extended to 16}`.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tlast` out 1: AXI4-Stream master.
- `o_overflow` out 1: sticky; set on the first dropped sample.
- `o_dropCount` out 16: count of dropped samples; saturates at 16'hFFFF.
- `o_level` out $clog2(FIFO_DEPTH)+1: number of occupied storage entries, excluding the output register.

## Operation
- Capture event: `i_tValid != 0` while the FSM is in RUN.
  - A lane whose valid bit is 0 is packed as 16'h0000.
  - Each event produces exactly one 33-bit FIFO entry: `{last, word}`.
- Frame counter `fcnt` covers 0..FRAME_LEN-1.
  - It increments on each accepted write.
  - `last`=1 when `fcnt == FRAME_LEN-1`; `fcnt` then wraps to 0.
  - Dropped events do not advance `fcnt`.
- Full handling: storage is full when `o_level == FIFO_DEPTH`.
  - A write while full is accepted only if storage pops in the same cycle.
  - Otherwise the event is dropped: `o_overflow` is set and `o_dropCount` increments (saturating).
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN when `i_enable`=1.
  - RUN → IDLE when `i_enable`=0 and `fcnt`=0.
  - RUN → DRAIN when `i_enable`=0 and `fcnt`≠0.
  - DRAIN writes terminator `FILL_WORD` = 32'hFFFF_FFFF with `last`=1 as soon as storage is not full, resets `fcnt` to 0, then goes to IDLE.
  - In DRAIN and IDLE, `i_tValid` is ignored: no capture and no drop count.
- Output stage: a first-word-fall-through register.
  - It loads from storage when it is empty, or when `m_axis_tvalid && m_axis_tready`.
  - `tdata` and `tlast` stay stable while `tvalid`=1 and `tready`=0.
- The FIFO drains in all states, so disabling capture never discards buffered data.

## Timing
- Reset (`i_rst`=0 at a clock edge) sets:
  - FSM to IDLE, `fcnt`=0.
  - FIFO pointers cleared, `o_level`=0.
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0.
  - `o_overflow`=0, `o_dropCount`=0.
- Reset mid-frame or mid-transfer discards all buffered data; no terminator is emitted.
- Latency, empty FIFO with `tready`=1: strobe at edge N puts the entry in storage after edge N+1, and `m_axis_tvalid`=1 after edge N+2.
- Throughput: one word per cycle when `tready` is held high. The SPI receiver emits at most one event per 48 cycles.
- `o_level` updates one cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- `i_enable` is sampled every cycle; a strobe in the same cycle as the RUN→DRAIN transition is not captured.

## Structure
- Package `adc_axis_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DRAIN} packer_state_t`.
  - `localparam FILL_WORD`.
  - Function `pack_word(data, valid)` returning 32 bits.
- Sub-module `sync_fifo` (parameters WIDTH=33, DEPTH): storage, pointers, level, full/empty, push/pop.
- Top level contains the FSM, frame counter, drop logic and output register.

## Test plan
- FRAME_LEN=4, `tready`=1, 8 events with ch0=12'h001..008 and ch1=12'h101..108 → 8 words such as 32'h0101_0001. `tlast` is set on words 4 and 8, and the first `tvalid` comes 2 cycles after the first strobe.
- `i_tValid`=2'b01 with `i_data`=24'hABC_123 → 32'h0000_0123.
- `tready`=0, FIFO_DEPTH+1+3 events → `o_level`=FIFO_DEPTH, `o_dropCount`=3, `o_overflow`=1. Releasing `tready` then delivers FIFO_DEPTH+1 words in order and the flags stay set.
- FRAME_LEN=4, 2 events, then `i_enable`=0 → 3 words; the third is 32'hFFFF_FFFF with `tlast`=1, and the FSM returns to IDLE.
- Random `tready` (50%) across 1000 events → order preserved, `tdata` and `tlast` held stable while stalled, and no drops.
- `i_rst`=0 for one cycle while `o_level`=5 → all outputs at reset values on the next cycle, and no stale words appear afterwards.
